cam_stream_pattern_gen: RTL and testbench

- Synthetic camera source that drives one camera-domain DVP-style stream (vs, href, de, RGB565 data).
- Replaces a physical sensor on the cam0/cam1 write side of the dual-camera decimating mux, for bring-up and regression.
- Produces the full frame timing: VSYNC, vertical back porch, active lines with horizontal blanking, vertical front porch.
- Pixel content comes from a selectable test pattern.

---
 rtl/cam_stream_pattern_gen.sv | 182 ++++++++++++++++++
 tb/tb_cam_stream_pattern_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_pattern_gen.sv
// ============================================================================
// cam_stream_pattern_gen : synthetic DVP camera source (vs/href/de/RGB565).
// Optional moving white bar: CAMGEN_MOVING_BAR_EN.            Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cam_stream_pattern_gen #(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int H_BLANK  = 160,
  parameter int VS_LINES = 4,
  parameter int V_BP     = 20,
  parameter int V_FP     = 5
) (
  input  logic        wr0_clk,
  input  logic        wr0_rst_n,
  input  logic        enable,
  input  logic [1:0]  pat_sel,
  output logic        vs,
  output logic        href,
  output logic        de,
  output logic [15:0] data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int L      = H_ACT + H_BLANK;
  localparam int V_MAX1 = (VS_LINES > V_BP) ? VS_LINES : V_BP;
  localparam int V_MAX2 = (V_ACT > V_FP) ? V_ACT : V_FP;
  localparam int V_MAX  = (V_MAX1 > V_MAX2) ? V_MAX1 : V_MAX2;
  localparam int HW     = (L > 1) ? $clog2(L) : 1;
  localparam int VW     = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int BW     = H_ACT / 8;
  localparam logic [HW-1:0] H_LAST = HW'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [HW-1:0]   r_h_cnt, w_h_nxt;
  logic [VW-1:0]   r_v_cnt, w_v_nxt, w_lines_last;
  logic [1:0]      r_pat_sel;
  logic [15:0]     r_start_cnt;
  logic            w_line_end, w_frame_end_nxt, w_vs_entry, w_act_nxt;
  logic [15:0]     w_x, w_bar_idx, w_pix;
  logic            w_y_b5;

  assign w_line_end = (r_h_cnt == H_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_h_nxt      = r_h_cnt;
    w_v_nxt      = r_v_cnt;
    w_lines_last = '0;
    case (r_state)
      S_VSYNC:  w_lines_last = VW'(VS_LINES - 1);
      S_VBP:    w_lines_last = VW'(V_BP - 1);
      S_ACTIVE: w_lines_last = VW'(V_ACT - 1);
      S_VFP:    w_lines_last = VW'(V_FP - 1);
      default:  w_lines_last = '0;
    endcase
    if (r_state == S_IDLE) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
      if (enable) w_state_nxt = S_VSYNC;
    end else begin
      w_h_nxt = w_line_end ? '0 : r_h_cnt + 1'b1;
      if (w_line_end) begin
        if (r_v_cnt == w_lines_last) begin
          w_v_nxt = '0;
          case (r_state)
            S_VSYNC:  w_state_nxt = S_VBP;
            S_VBP:    w_state_nxt = S_ACTIVE;
            S_ACTIVE: w_state_nxt = S_VFP;
            S_VFP:    w_state_nxt = enable ? S_VSYNC : S_IDLE;
            default:  w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_v_nxt = r_v_cnt + 1'b1;
        end
      end
    end
  end

  // Outputs are registered from next-state values so they line up with the state register.
  assign w_frame_end_nxt = (w_state_nxt == S_VFP) && (w_h_nxt == H_LAST) &&
                           (w_v_nxt == VW'(V_FP - 1));
  assign w_vs_entry      = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);
  assign w_act_nxt       = (w_state_nxt == S_ACTIVE) && (w_h_nxt < HW'(H_ACT));
  assign w_x             = 16'(w_h_nxt);
  assign w_y_b5          = ((32'(w_v_nxt) >> 5) & 32'd1) != 32'd0;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

`ifdef CAMGEN_MOVING_BAR_EN
  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  logic [XW-1:0] r_bar_pos;
  logic [XW:0]   w_x_b, w_bar_e, w_bar_diff, w_bar_adv;
  logic          w_in_bar;

  assign w_x_b      = {1'b0, w_h_nxt[XW-1:0]};
  assign w_bar_e    = {1'b0, r_bar_pos};
  assign w_bar_diff = (w_x_b >= w_bar_e) ? (w_x_b - w_bar_e)
                                         : (w_x_b + (XW+1)'(H_ACT) - w_bar_e);
  assign w_in_bar   = (w_bar_diff < (XW+1)'(8));
  assign w_bar_adv  = w_bar_e + (XW+1)'(4);

  always_ff @(posedge wr0_clk or negedge wr0_rst_n) begin
    if (!wr0_rst_n) begin
      r_bar_pos <= '0;
    end else if (w_frame_end_nxt) begin
      r_bar_pos <= (w_bar_adv >= (XW+1)'(H_ACT)) ? XW'(w_bar_adv - (XW+1)'(H_ACT))
                                                 : w_bar_adv[XW-1:0];
    end
  end
`endif

  always_comb begin
    w_bar_idx = w_x / 16'(BW);
    w_pix     = 16'h0000;
    case (r_pat_sel)
      2'd0:    w_pix = bar_colour((w_bar_idx > 16'd7) ? 3'd7 : w_bar_idx[2:0]);
      2'd1:    w_pix = {w_x[7:3], w_x[7:2], w_x[7:3]};
      2'd2:    w_pix = (w_x[5] ^ w_y_b5) ? 16'hFFFF : 16'h0000;
      default: w_pix = r_start_cnt;
    endcase
`ifdef CAMGEN_MOVING_BAR_EN
    if (w_in_bar) w_pix = 16'hFFFF;
`endif
  end

  always_ff @(posedge wr0_clk or negedge wr0_rst_n) begin
    if (!wr0_rst_n) begin
      r_state     <= S_IDLE;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_pat_sel   <= 2'd0;
      r_start_cnt <= 16'h0000;
      vs          <= 1'b0;
      href        <= 1'b0;
      de          <= 1'b0;
      data        <= 16'h0000;
      frame_done  <= 1'b0;
      frame_cnt   <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_h_cnt    <= w_h_nxt;
      r_v_cnt    <= w_v_nxt;
      vs         <= (w_state_nxt == S_VSYNC);
      href       <= w_act_nxt;
      de         <= w_act_nxt;
      data       <= w_act_nxt ? w_pix : 16'h0000;
      frame_done <= w_frame_end_nxt;
      if (w_frame_end_nxt) frame_cnt <= frame_cnt + 16'd1;
      // frame_cnt has already stepped by the time the next VSYNC is entered.
      if (w_vs_entry) begin
        r_pat_sel   <= pat_sel;
        r_start_cnt <= frame_cnt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cam_stream_pattern_gen.sv
// ============================================================================
// tb_cam_stream_pattern_gen : scoreboard bench for the camera pattern source.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cam_stream_pattern_gen;

  localparam int H_ACT = 16, V_ACT = 4, H_BLANK = 4, VS_LINES = 1, V_BP = 1, V_FP = 1;
  localparam int L        = H_ACT + H_BLANK;
  localparam int FIRST_DE = (VS_LINES + V_BP) * L;
  localparam int FRAME    = (VS_LINES + V_BP + V_ACT + V_FP) * L;
  localparam int H2 = 64, V2 = 64, L2 = H2 + 4;
  localparam int FIRST2   = 2 * L2;
  localparam int FRAME2   = (3 + V2) * L2;

  typedef struct { logic [15:0] data; int off; } pix_t;

  logic        wr0_clk, wr0_rst_n, enable;
  logic [1:0]  pat_sel;
  logic        vs, href, de, frame_done;
  logic [15:0] data, frame_cnt;
  logic        rst2_n, en2;
  logic [1:0]  pat_sel2;
  logic        vs2, href2, de2, frame_done2;
  logic [15:0] data2, frame_cnt2;

  int checks = 0, errors = 0;
  pix_t exp_pix[$], exp_pix2[$];
  logic [15:0] exp_fd[$], exp_fd2[$];
  logic done2 = 1'b0;

  logic [15:0] bars16 [16] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF,
                               16'h07E0, 16'h07E0, 16'hF81F, 16'hF81F, 16'hF800, 16'hF800,
                               16'h001F, 16'h001F, 16'h0000, 16'h0000};

  cam_stream_pattern_gen #(.H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BLANK),
                           .VS_LINES(VS_LINES), .V_BP(V_BP), .V_FP(V_FP)) dut (
    .wr0_clk(wr0_clk), .wr0_rst_n(wr0_rst_n), .enable(enable), .pat_sel(pat_sel),
    .vs(vs), .href(href), .de(de), .data(data),
    .frame_done(frame_done), .frame_cnt(frame_cnt));

  cam_stream_pattern_gen #(.H_ACT(H2), .V_ACT(V2), .H_BLANK(4),
                           .VS_LINES(1), .V_BP(1), .V_FP(1)) dut2 (
    .wr0_clk(wr0_clk), .wr0_rst_n(rst2_n), .enable(en2), .pat_sel(pat_sel2),
    .vs(vs2), .href(href2), .de(de2), .data(data2),
    .frame_done(frame_done2), .frame_cnt(frame_cnt2));

  initial wr0_clk = 1'b0;
  always #5 wr0_clk = ~wr0_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pix(input int pat, input int x, input int y,
                                            input int n, input int hact);
    logic [7:0]  g;
    logic [15:0] p;
    g = 8'(x);
    case (pat)
      0:       p = bars16[x];
      1:       p = {g[7:3], g[7:2], g[7:3]};
      2:       p = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: p = 16'(n);
    endcase
`ifdef CAMGEN_MOVING_BAR_EN
    if ((((x - 4 * n) % hact) + hact) % hact < 8) p = 16'hFFFF;
`endif
    return p;
  endfunction

  task automatic push_frame(input int pat, input int n);
    pix_t e;
    for (int y = 0; y < V_ACT; y++)
      for (int x = 0; x < H_ACT; x++) begin
        e.data = model_pix(pat, x, y, n, H_ACT);
        e.off  = FIRST_DE + y * L + x;
        exp_pix.push_back(e);
      end
    exp_fd.push_back(16'(n + 1));
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    @(negedge wr0_clk);
    while (frame_done !== 1'b1 && n < 400) begin
      @(negedge wr0_clk);
      n++;
    end
    if (frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no frame_done expected one within 400 cycles", tag);
    end
  endtask

  // Monitor for the 16x4 instance: pixels, timing and frame_done against the queues.
  int   fcyc = 0, vs_run = 0;
  logic vs_q = 1'b0;
  pix_t pe;
  always @(negedge wr0_clk) begin
    if (vs === 1'b1 && vs_q !== 1'b1) begin fcyc = 0; vs_run = 0; end
    else fcyc++;
    if (vs === 1'b1) vs_run++;
    else if (vs_q === 1'b1) check("vs_width", 32'(vs_run), 32'(VS_LINES * L));
    vs_q = vs;
    if (de === 1'b1) begin
      if (exp_pix.size() == 0) check("unexpected_de", 32'(de), 32'd0);
      else begin
        pe = exp_pix.pop_front();
        check("pixel", 32'(data), 32'(pe.data));
        check("pixel_time", 32'(fcyc), 32'(pe.off));
        check("href_with_de", 32'(href), 32'd1);
      end
    end else if (wr0_rst_n === 1'b1) begin
      check("blank_out", {15'd0, href, data}, 32'd0);
    end
    if (frame_done === 1'b1) begin
      if (exp_fd.size() == 0) check("unexpected_fd", 32'(frame_done), 32'd0);
      else begin
        check("frame_cnt", 32'(frame_cnt), 32'(exp_fd.pop_front()));
        check("fd_time", 32'(fcyc), 32'(FRAME - 1));
      end
    end
  end

  int   fcyc2 = 0;
  logic vs2_q = 1'b0;
  pix_t pe2;
  always @(negedge wr0_clk) begin
    if (vs2 === 1'b1 && vs2_q !== 1'b1) fcyc2 = 0;
    else fcyc2++;
    vs2_q = vs2;
    if (de2 === 1'b1) begin
      if (exp_pix2.size() == 0) check("unexpected_de2", 32'(de2), 32'd0);
      else begin
        pe2 = exp_pix2.pop_front();
        check("checker_pixel", 32'(data2), 32'(pe2.data));
        check("checker_time", 32'(fcyc2), 32'(pe2.off));
      end
    end
    if (frame_done2 === 1'b1) begin
      if (exp_fd2.size() == 0) check("unexpected_fd2", 32'(frame_done2), 32'd0);
      else begin
        check("frame_cnt2", 32'(frame_cnt2), 32'(exp_fd2.pop_front()));
        check("fd_time2", 32'(fcyc2), 32'(FRAME2 - 1));
      end
    end
  end

  initial begin
    pix_t e;
    rst2_n = 1'b0; en2 = 1'b0; pat_sel2 = 2'd0;
    for (int y = 0; y < V2; y++)
      for (int x = 0; x < H2; x++) begin
        e.data = model_pix(2, x, y, 0, H2);
        e.off  = FIRST2 + y * L2 + x;
        exp_pix2.push_back(e);
      end
    exp_fd2.push_back(16'd1);
    repeat (3) @(negedge wr0_clk);
    rst2_n = 1'b1;
    @(negedge wr0_clk);
    en2 = 1'b1; pat_sel2 = 2'd2;
    repeat (200) @(negedge wr0_clk);
    en2 = 1'b0;
    for (int i = 0; i < FRAME2 && frame_done2 !== 1'b1; i++) @(negedge wr0_clk);
    done2 = 1'b1;
  end

  initial begin
    wr0_rst_n = 1'b0; enable = 1'b0; pat_sel = 2'd0;
    repeat (3) @(negedge wr0_clk);
    check("rst_vs", 32'(vs), 32'd0);
    check("rst_href", 32'(href), 32'd0);
    check("rst_de", 32'(de), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    wr0_rst_n = 1'b1;
    repeat (5) @(negedge wr0_clk);
    check("idle_vs", 32'(vs), 32'd0);

    // Frames 0..2 solid frame count; pat_sel=1 requested mid frame 2 shows in frame 3.
    push_frame(3, 0); push_frame(3, 1); push_frame(3, 2); push_frame(1, 3);
    pat_sel = 2'd3; enable = 1'b1;
    @(negedge wr0_clk);
    check("vs_start", 32'(vs), 32'd1);
    wait_fd("f0");
    wait_fd("f1");
    repeat (60) @(negedge wr0_clk);
    pat_sel = 2'd1;
    wait_fd("f2");
    repeat (60) @(negedge wr0_clk);
    pat_sel = 2'd0; enable = 1'b0;
    wait_fd("f3");
    repeat (30) @(negedge wr0_clk);
    check("idle_after_stop_vs", 32'(vs), 32'd0);
    check("idle_after_stop_cnt", 32'(frame_cnt), 32'd4);

    // Colour bars, then a checker frame cut short by reset.
    push_frame(0, 4); push_frame(2, 5);
    enable = 1'b1;
    repeat (60) @(negedge wr0_clk);
    pat_sel = 2'd2;
    wait_fd("f4");
    repeat (61) @(negedge wr0_clk);
    check("pre_rst_de", 32'(de), 32'd1);
    #2 wr0_rst_n = 1'b0;
    #1;
    check("async_rst_vs", 32'(vs), 32'd0);
    check("async_rst_href", 32'(href), 32'd0);
    check("async_rst_de", 32'(de), 32'd0);
    check("async_rst_data", 32'(data), 32'd0);
    check("async_rst_cnt", 32'(frame_cnt), 32'd0);
    exp_pix.delete();
    exp_fd.delete();
    enable = 1'b0;
    repeat (2) @(negedge wr0_clk);
    wr0_rst_n = 1'b1;

    push_frame(0, 0);
    pat_sel = 2'd0; enable = 1'b1;
    @(negedge wr0_clk);
    check("vs_restart", 32'(vs), 32'd1);
    repeat (60) @(negedge wr0_clk);
    enable = 1'b0;
    wait_fd("f_restart");
    repeat (10) @(negedge wr0_clk);
    check("restart_cnt", 32'(frame_cnt), 32'd1);
    check("restart_idle_vs", 32'(vs), 32'd0);

    for (int i = 0; i < FRAME2 && !done2; i++) @(negedge wr0_clk);
    check("checker_done", 32'(done2), 32'd1);
    repeat (5) @(negedge wr0_clk);
    check("queues_drained",
          32'(exp_pix.size() + exp_fd.size() + exp_pix2.size() + exp_fd2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
